// File: rtl/key_event_arbiter.sv
// key_event_arbiter
// Purpose: captures one-cycle press pulses from a bank of key filters, holds
// each press as a pending request, and hands the requests one at a time to a
// downstream consumer over a valid/ready handshake in round-robin order.
// A press that lands on an already-pending request is merged and flagged.
//
// Optional build macro: KEY_ARB_LOST_CNT_EN
//   When defined, adds lost_cnt[7:0], a saturating count of merged presses
//   (at most one per cycle). When undefined the port and logic are absent.
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst    in   asynchronous active-high reset
//   key_pulse  in   [KEY_NUM-1:0] one-cycle press pulses, bit i = key i
//   evt_valid  out  event available (registered)
//   evt_ready  in   consumer accepts when evt_valid && evt_ready
//   evt_idx    out  [IDX_W-1:0] key index of the current event (registered)
//   pending    out  [KEY_NUM-1:0] registered pending-request vector
//   evt_lost   out  sticky flag: a press was merged into a pending request
//   clr_lost   in   synchronous clear of evt_lost (a new loss wins)
//   lost_cnt   out  [7:0] merged-press counter (KEY_ARB_LOST_CNT_EN only)
module key_event_arbiter #(
  parameter int KEY_NUM = 4,
  parameter int IDX_W   = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [KEY_NUM-1:0] key_pulse,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [IDX_W-1:0]   evt_idx,
  output logic [KEY_NUM-1:0] pending,
  output logic               evt_lost,
  input  logic               clr_lost
`ifdef KEY_ARB_LOST_CNT_EN
  ,
  output logic [7:0]         lost_cnt
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_r, state_nx_s;
  logic [IDX_W-1:0]   idx_r, idx_nx_s;
  logic [IDX_W-1:0]   ptr_r, ptr_nx_s;
  logic [KEY_NUM-1:0] pend_r, pend_nx_s;
  logic               lost_r, lost_nx_s;

  logic               hit_s;
  logic [IDX_W-1:0]   gidx_s;
  logic [IDX_W:0]     pos_s;
  logic               load_s;
  logic               grant_s;
  logic [KEY_NUM-1:0] gvec_s;
  logic               lost_any_s;

  localparam logic [KEY_NUM-1:0] ONE_HOT0 = {{(KEY_NUM-1){1'b0}}, 1'b1};

`ifdef KEY_ARB_LOST_CNT_EN
  logic [7:0] cnt_r, cnt_nx_s;
`endif

  // Round-robin scan of the registered pending vector starting at ptr.
  // The wrap is done against KEY_NUM so indices >= KEY_NUM never appear.
  always_comb begin
    hit_s  = 1'b0;
    gidx_s = {IDX_W{1'b0}};
    pos_s  = {(IDX_W+1){1'b0}};
    for (int k = 0; k < KEY_NUM; k++) begin
      pos_s = {1'b0, ptr_r} + (IDX_W+1)'(k);
      if (pos_s >= (IDX_W+1)'(KEY_NUM)) begin
        pos_s = pos_s - (IDX_W+1)'(KEY_NUM);
      end else begin
        pos_s = pos_s;
      end
      if (!hit_s && pend_r[pos_s[IDX_W-1:0]]) begin
        hit_s  = 1'b1;
        gidx_s = pos_s[IDX_W-1:0];
      end else begin
        hit_s  = hit_s;
      end
    end
  end

  // Next-state for the output register FSM, pending vector, pointer and flags.
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = idx_r;
    ptr_nx_s   = ptr_r;
    // The output register can take a new event when empty or being drained.
    load_s     = (state_r == EMPTY) || evt_ready;
    grant_s    = load_s && hit_s;
    gvec_s     = grant_s ? (ONE_HOT0 << gidx_s) : {KEY_NUM{1'b0}};
    // A pulse on the key being granted re-arms it rather than being lost.
    pend_nx_s  = (pend_r & ~gvec_s) | key_pulse;
    lost_any_s = |(key_pulse & pend_r & ~gvec_s);

    case (state_r)
      EMPTY: state_nx_s = hit_s ? FULL : EMPTY;
      FULL: begin
        if (evt_ready) begin
          state_nx_s = hit_s ? FULL : EMPTY;
        end else begin
          state_nx_s = FULL;
        end
      end
      default: state_nx_s = EMPTY;
    endcase

    if (grant_s) begin
      idx_nx_s = gidx_s;
      ptr_nx_s = (gidx_s == IDX_W'(KEY_NUM-1)) ? {IDX_W{1'b0}}
                                                : gidx_s + IDX_W'(1'b1);
    end else begin
      idx_nx_s = idx_r;
      ptr_nx_s = ptr_r;
    end

    if (lost_any_s) begin
      lost_nx_s = 1'b1;
    end else if (clr_lost) begin
      lost_nx_s = 1'b0;
    end else begin
      lost_nx_s = lost_r;
    end
  end

  // State, pending, pointer and sticky-flag registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r <= EMPTY;
      idx_r   <= {IDX_W{1'b0}};
      ptr_r   <= {IDX_W{1'b0}};
      pend_r  <= {KEY_NUM{1'b0}};
      lost_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      idx_r   <= idx_nx_s;
      ptr_r   <= ptr_nx_s;
      pend_r  <= pend_nx_s;
      lost_r  <= lost_nx_s;
    end
  end

`ifdef KEY_ARB_LOST_CNT_EN
  // Saturating merged-press counter; one step per cycle, increment beats clear.
  always_comb begin
    if (lost_any_s) begin
      cnt_nx_s = (cnt_r == 8'hFF) ? cnt_r : cnt_r + 8'd1;
    end else if (clr_lost) begin
      cnt_nx_s = 8'd0;
    end else begin
      cnt_nx_s = cnt_r;
    end
  end

  // Merged-press counter register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_r <= 8'd0;
    end else begin
      cnt_r <= cnt_nx_s;
    end
  end

  assign lost_cnt = cnt_r;
`endif

  assign evt_valid = (state_r == FULL);
  assign evt_idx   = idx_r;
  assign pending   = pend_r;
  assign evt_lost  = lost_r;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Self-checking bench for key_event_arbiter: a hand-derived vector table,
// a reset-during-handshake sequence, and randomized traffic compared against
// a behavioural model of the arbitration rules.
module tb_key_event_arbiter;
  localparam int N = 4;
  localparam int W = 2;

  logic         sys_clk = 1'b0;
  logic         sys_rst = 1'b0;
  logic [N-1:0] key_pulse = 4'b0000;
  logic         evt_ready = 1'b0;
  logic         clr_lost = 1'b0;
  logic         evt_valid;
  logic [W-1:0] evt_idx;
  logic [N-1:0] pending;
  logic         evt_lost;
`ifdef KEY_ARB_LOST_CNT_EN
  logic [7:0]   lost_cnt;
`endif

  key_event_arbiter #(.KEY_NUM(N), .IDX_W(W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_pulse (key_pulse),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_idx   (evt_idx),
    .pending   (pending),
    .evt_lost  (evt_lost),
    .clr_lost  (clr_lost)
`ifdef KEY_ARB_LOST_CNT_EN
    ,
    .lost_cnt  (lost_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending requests as a bit array, plain modulo scan.
  int m_pend[N];
  int m_valid, m_idx, m_ptr, m_lost, m_cnt;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_pend[i] = 0;
    m_valid = 0; m_idx = 0; m_ptr = 0; m_lost = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic [N-1:0] p, input logic r, input logic c);
    int g;
    int lost;
    int np[N];
    bit load;
    load = (m_valid == 0) || r;
    g = -1;
    if (load) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (g < 0 && m_pend[j] != 0) g = j;
      end
    end
    lost = 0;
    for (int i = 0; i < N; i++) begin
      if (p[i] && m_pend[i] != 0 && i != g) lost = 1;
      np[i] = (p[i] || (m_pend[i] != 0 && i != g)) ? 1 : 0;
    end
    for (int i = 0; i < N; i++) m_pend[i] = np[i];
    if (lost != 0) m_lost = 1;
    else if (c) m_lost = 0;
    if (lost != 0) begin
      if (m_cnt < 255) m_cnt++;
    end else if (c) m_cnt = 0;
    if (load) begin
      if (g >= 0) begin
        m_valid = 1; m_idx = g; m_ptr = (g + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  function automatic logic [N-1:0] model_pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (m_pend[i] != 0);
    return v;
  endfunction

  task automatic cmp_model(input string tag);
    check({tag, ".valid"},   32'(evt_valid), 32'(m_valid));
    if (m_valid != 0) check({tag, ".idx"}, 32'(evt_idx), 32'(m_idx));
    check({tag, ".pending"}, 32'(pending),   32'(model_pend_vec()));
    check({tag, ".lost"},    32'(evt_lost),  32'(m_lost));
`ifdef KEY_ARB_LOST_CNT_EN
    check({tag, ".cnt"},     32'(lost_cnt),  32'(m_cnt));
`endif
  endtask

  // Apply one cycle of inputs, advance the model at the edge, compare after it.
  task automatic cycle(input logic [N-1:0] p, input logic r, input logic c, input string tag);
    key_pulse = p; evt_ready = r; clr_lost = c;
    @(posedge sys_clk);
    model_step(p, r, c);
    #1;
    cmp_model(tag);
  endtask

  typedef struct {
    logic [N-1:0] p;
    logic         r;
    logic         c;
    logic         ev;
    logic [W-1:0] ei;
    logic [N-1:0] ep;
    logic         el;
  } vec_t;

  vec_t tbl[31];

  initial begin
    tbl = '{
      '{4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1111, 1'b0},
      '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b1110, 1'b0},
      '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1100, 1'b0},
      '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b1000, 1'b0},
      '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b0000, 1'b0},
      '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b0},
      '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0100, 1'b0},
      '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0},
      '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0},
      '{4'b0010, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0010, 1'b0},
      '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0},
      '{4'b0011, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0011, 1'b0},
      '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0010, 1'b0},
      '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0},
      '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0},
      '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0100, 1'b0},
      '{4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0},
      '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0},
      '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0},
      '{4'b1000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b1000, 1'b0},
      '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0000, 1'b0},
      '{4'b1000, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0},
      '{4'b1000, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1},
      '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1},
      '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b0000, 1'b1},
      '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0},
      '{4'b0001, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0001, 1'b0},
      '{4'b0001, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0},
      '{4'b0001, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1},
      '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b1},
      '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0}
    };

    // Power-on reset, checked while asserted.
    #1 sys_rst = 1'b1;
    #2;
    check("rst.valid",   32'(evt_valid), 32'd0);
    check("rst.idx",     32'(evt_idx),   32'd0);
    check("rst.pending", 32'(pending),   32'd0);
    check("rst.lost",    32'(evt_lost),  32'd0);
    model_reset();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // Hand-derived vectors from reset.
    for (int i = 0; i < 31; i++) begin
      cycle(tbl[i].p, tbl[i].r, tbl[i].c, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.ev", i), 32'(evt_valid), 32'(tbl[i].ev));
      check($sformatf("tbl%0d.ei", i), 32'(evt_idx),   32'(tbl[i].ei));
      check($sformatf("tbl%0d.ep", i), 32'(pending),   32'(tbl[i].ep));
      check($sformatf("tbl%0d.el", i), 32'(evt_lost),  32'(tbl[i].el));
    end

    // Reset in the middle of a stalled handshake with requests pending.
    cycle(4'b1010, 1'b0, 1'b0, "mr0");
    cycle(4'b0000, 1'b0, 1'b0, "mr1");
    cycle(4'b0010, 1'b0, 1'b0, "mr2");
    cycle(4'b1000, 1'b0, 1'b0, "mr3");
    check("mr.pre_valid",   32'(evt_valid), 32'd1);
    check("mr.pre_pending", 32'(pending),   32'(4'b1010));
    check("mr.pre_lost",    32'(evt_lost),  32'd1);
    key_pulse = 4'b0000;
    sys_rst = 1'b1;
    #1;
    check("mr.valid",   32'(evt_valid), 32'd0);
    check("mr.pending", 32'(pending),   32'd0);
    check("mr.lost",    32'(evt_lost),  32'd0);
    check("mr.idx",     32'(evt_idx),   32'd0);
    model_reset();
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    cycle(4'b1001, 1'b1, 1'b0, "pr0");
    check("pr0.pending", 32'(pending), 32'(4'b1001));
    cycle(4'b0000, 1'b1, 1'b0, "pr1");
    check("pr1.idx", 32'(evt_idx), 32'd0);
    cycle(4'b0000, 1'b1, 1'b0, "pr2");
    check("pr2.idx", 32'(evt_idx), 32'd3);
    cycle(4'b0000, 1'b1, 1'b0, "pr3");
    check("pr3.valid", 32'(evt_valid), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] p;
      logic r, c;
      p = ($urandom_range(0, 2) == 0) ? N'($urandom) : 4'b0000;
      r = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 9) == 0);
      cycle(p, r, c, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/key_event_arbiter.md
Name: key_event_arbiter

Overview:
- Collects one-cycle press pulses from KEY_NUM key debounce filters.
- Holds each press as a pending request and arbitrates the pending requests round-robin.
- Presents one key event at a time to the downstream consumer (LED/mode control FSM) over a valid/ready handshake.
- Sits between the bank of key filters and the application control logic; no press is silently lost: merged presses are flagged.

Parameters:
- KEY_NUM, 4, number of key inputs (2..16).
- IDX_W, 2, width of event index; must satisfy 2^IDX_W >= KEY_NUM.

Ports:
- sys_clk  input  1  system clock.
- sys_rst  input  1  asynchronous, active-high reset.
- key_pulse  input  KEY_NUM  one-cycle press pulses from the filters, bit i = key i.
- evt_valid  output  1  event available.
- evt_ready  input  1  consumer accepts the event when evt_valid && evt_ready.
- evt_idx  output  IDX_W  index of the key for the current event.
- pending  output  KEY_NUM  registered pending-request vector (status).
- evt_lost  output  1  sticky flag: a press was merged into an already-pending request.
- clr_lost  input  1  synchronous clear of evt_lost.

Behaviour:
- Reset values (asynchronous, while sys_rst=1):
  - evt_valid=0, evt_idx=0, pending=0, evt_lost=0.
  - Round-robin pointer ptr=0.
- Pending register, per bit i, evaluated at each edge:
  - Set when key_pulse[i]=1.
  - Cleared when key i is granted (loaded into the output register).
  - If a pulse and a grant of i occur in the same cycle, pending[i] ends at 1 (the new press is kept).
- Lost detection:
  - Condition: key_pulse[i]=1 && pending[i]=1 && i not granted this cycle.
  - Result: evt_lost <= 1 and the press is merged.
  - If clr_lost and a lost event occur in the same cycle, set wins.
- Output register, two states: EMPTY (evt_valid=0) and FULL (evt_valid=1).
  - Load condition: state EMPTY, or state FULL with evt_valid && evt_ready this cycle. When it holds and pending != 0:
    - Grant the first set pending bit at or after ptr, scanning ptr, ptr+1, …, KEY_NUM-1, 0, …, ptr-1.
    - evt_idx <= granted index; evt_valid <= 1.
    - ptr <= (granted+1) mod KEY_NUM.
  - Load condition holds and pending == 0: evt_valid <= 0.
  - FULL and not ready: evt_idx and evt_valid held stable; pending continues to accumulate.
- Latency and throughput:
  - key_pulse at edge t → pending at t+1 → evt_valid/evt_idx at t+2 (when empty).
  - Sustained throughput is one event per cycle with evt_ready tied high.
- Arbitration uses only the registered pending vector, never raw key_pulse.
- Simultaneous pulses on several keys are all captured; they are emitted in round-robin order from ptr.
- Fairness bound: a pending key waits at most KEY_NUM-1 grants.
- Out-of-range indices (KEY_NUM < 2^IDX_W) are never produced; the ptr wrap uses KEY_NUM, not 2^IDX_W.
- Reset mid-handshake discards the in-flight event and all pending requests immediately.

Optional Feature:
- Macro: KEY_ARB_LOST_CNT_EN.
- Defined:
  - Adds output lost_cnt[7:0]: counts lost (merged) presses, saturating at 255.
  - Counts at most one per cycle, even if several keys are lost in that cycle.
  - Reset value 0; cleared by clr_lost, with increment winning over clear in the same cycle.
- Undefined: lost_cnt port and logic are absent; evt_lost behaves identically in both builds.

Test Plan:
- Reset, then key_pulse=4'b0100 for one cycle with evt_ready=1 → pending[2]=1 one cycle later; evt_valid=1, evt_idx=2 the cycle after, for one cycle; then evt_valid=0; evt_lost=0.
- key_pulse=4'b1111 in one cycle, evt_ready=1, ptr=0 → evt_idx sequence 0,1,2,3 on four consecutive cycles with evt_valid continuously 1, then 0.
- Event idx=1 accepted (ptr=2), then key_pulse=4'b0011 → order 0? no: scan from 2 yields idx 0 then 1.
- evt_ready=0 with evt_idx=3 held, pulse key 3 twice → first sets pending[3], second sets evt_lost=1 (lost_cnt=1 if enabled); evt_idx stays 3 until ready.
- Accept of key 2 in the same cycle as key_pulse[2]=1 → pending[2] remains 1; next event idx=2; evt_lost stays 0.
- sys_rst pulsed while evt_valid=1 and pending=4'b1010 → evt_valid, pending, evt_lost drop to 0 asynchronously; after release, ptr=0, so key_pulse=4'b1001 yields idx 0 then 3.
